// File: rtl/saida_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : saida_bcd_seq_if
// Brief    : Datapath-to-display bundle for the BCD output stage.
// Revision : 1.0 - initial release
// ============================================================================
interface saida_bcd_seq_if #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4,
  parameter int LED_W  = 14
);
  logic [DATA_W-1:0]   ValorSaida;
  logic                EnableOut;
  logic                halt;
  logic [7*DIGITS-1:0] Segs;
  logic [LED_W-1:0]    Led;
  logic                Busy;
  logic                Overflow;

  modport master (
    output ValorSaida, EnableOut, halt,
    input  Segs, Led, Busy, Overflow
  );

  modport slave (
    input  ValorSaida, EnableOut, halt,
    output Segs, Led, Busy, Overflow
  );
endinterface
`default_nettype wire

// File: rtl/saida_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : saida_bcd_seq
// Brief    : Output stage with serial double-dabble BCD conversion driving a
//            7-segment bank and LED mirror, with one-deep pending buffer.
// Revision : 1.0 - initial release
// ============================================================================
module saida_bcd_seq #(
  parameter int DATA_W         = 32,
  parameter int DIGITS         = 4,
  parameter int LED_W          = 14,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZB            = 1'b1
) (
  input  wire logic      Clock,
  input  wire logic      Reset,
  saida_bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] c_DASH_OUT  = SEG_ACTIVE_LOW ? c_SEG_DASH  : ~c_SEG_DASH;
  localparam logic [6:0] c_BLANK_OUT = SEG_ACTIVE_LOW ? c_SEG_BLANK : ~c_SEG_BLANK;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} code, then flipped for common-cathode boards
  function automatic logic [6:0] segOut(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = c_SEG_DASH;
    endcase
    return SEG_ACTIVE_LOW ? code : ~code;
  endfunction

  state_t              r_state;
  state_t              w_nextState;
  logic [DATA_W-1:0]   r_shift;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_adj;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_pend;
  logic                r_pendValid;
  logic                r_loadPend;
  logic [7*DIGITS-1:0] r_segs;
  logic [7*DIGITS-1:0] w_commitSegs;
  logic [LED_W-2:0]    r_ledMirror;
  logic                r_haltLed;
  logic                r_overflow;

  logic w_write;
  logic w_busy;
  logic w_capture;
  logic w_loadFromPend;
  logic w_step;
  logic w_commit;
  logic w_armPend;

  assign w_write = bus.EnableOut & ~bus.halt;
  assign w_busy  = (r_state != IDLE);

  always_ff @(posedge Clock) begin : p_state
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A COMMIT with work queued returns to CONV with a load cycle first, so
  // the queued value is consumed one edge after the display update.
  always_comb begin : p_fsm
    w_nextState    = r_state;
    w_capture      = 1'b0;
    w_loadFromPend = 1'b0;
    w_step         = 1'b0;
    w_commit       = 1'b0;
    w_armPend      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_write) begin
          w_capture   = 1'b1;
          w_nextState = CONV;
        end
      end
      CONV: begin
        if (r_loadPend) begin
          w_loadFromPend = 1'b1;
        end else begin
          w_step = 1'b1;
          if (r_cnt == '0) begin
            w_nextState = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_armPend   = r_pendValid | w_write;
        w_nextState = w_armPend ? CONV : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin : p_adjust
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Scan from the most significant digit; blanking stops at the first nonzero
  always_comb begin : p_display
    logic lead;
    lead         = LZB;
    w_commitSegs = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      if (r_ovf) begin
        w_commitSegs[7*i +: 7] = c_DASH_OUT;
      end else if (lead && (i != 0)) begin
        w_commitSegs[7*i +: 7] = c_BLANK_OUT;
      end else begin
        w_commitSegs[7*i +: 7] = segOut(r_bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge Clock) begin : p_datapath
    if (Reset) begin
      r_shift     <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_loadPend  <= 1'b0;
      r_segs      <= {DIGITS{c_DASH_OUT}};
      r_ledMirror <= '0;
      r_haltLed   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_haltLed <= bus.halt;

      if (w_write) begin
        r_ledMirror <= bus.ValorSaida[LED_W-2:0];
      end

      // A write landing on the same edge as the pending load survives it
      if (w_loadFromPend) begin
        r_pendValid <= 1'b0;
      end
      if (w_write && w_busy) begin
        r_pend      <= bus.ValorSaida;
        r_pendValid <= 1'b1;
      end

      if (w_capture) begin
        r_shift <= bus.ValorSaida;
        r_bcd   <= '0;
        r_ovf   <= 1'b0;
        r_cnt   <= CNT_W'(DATA_W - 1);
      end

      if (w_loadFromPend) begin
        r_shift    <= r_pend;
        r_bcd      <= '0;
        r_ovf      <= 1'b0;
        r_cnt      <= CNT_W'(DATA_W - 1);
        r_loadPend <= 1'b0;
      end

      if (w_step) begin
        r_bcd   <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_ovf   <= r_ovf | w_adj[BCD_W-1];
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      if (w_commit) begin
        r_overflow <= r_ovf;
        r_segs     <= w_commitSegs;
        r_loadPend <= w_armPend;
      end
    end
  end

  assign bus.Segs     = r_segs;
  assign bus.Led      = {r_haltLed, r_ledMirror};
  assign bus.Busy     = w_busy;
  assign bus.Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_saida_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_saida_bcd_seq
// Brief    : Directed self-checking bench for saida_bcd_seq (32-bit, 4 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_saida_bcd_seq;

  localparam int DATA_W = 32;
  localparam int DIGITS = 4;
  localparam int LED_W  = 14;

  localparam logic [6:0] c_S0    = 7'b1000000;
  localparam logic [6:0] c_S1    = 7'b1111001;
  localparam logic [6:0] c_S2    = 7'b0100100;
  localparam logic [6:0] c_S3    = 7'b0110000;
  localparam logic [6:0] c_S4    = 7'b0011001;
  localparam logic [6:0] c_S7    = 7'b1111000;
  localparam logic [6:0] c_S9    = 7'b0010000;
  localparam logic [6:0] c_BLANK = 7'b1111111;
  localparam logic [6:0] c_DASH  = 7'b0111111;

  logic Clock;
  logic Reset;
  int   nChecks;
  int   nPass;

  saida_bcd_seq_if #(.DATA_W(DATA_W), .DIGITS(DIGITS), .LED_W(LED_W)) bus ();

  saida_bcd_seq #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .LED_W(LED_W),
    .SEG_ACTIVE_LOW(1'b1), .LZB(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      nPass++;
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge
  task automatic doWrite(input logic [DATA_W-1:0] value);
    bus.ValorSaida = value;
    bus.EnableOut  = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.EnableOut  = 1'b0;
  endtask

  function automatic logic [27:0] segs4(input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  logic [27:0] seg11;
  logic [27:0] seg22;
  logic [27:0] seg33;
  int          busyLow;
  bit          saw22;

  initial begin
    nChecks        = 0;
    nPass          = 0;
    busyLow        = 0;
    saw22          = 1'b0;
    seg11          = segs4(c_BLANK, c_BLANK, c_S1, c_S1);
    seg22          = segs4(c_BLANK, c_BLANK, c_S2, c_S2);
    seg33          = segs4(c_BLANK, c_BLANK, c_S3, c_S3);
    Reset          = 1'b1;
    bus.ValorSaida = '0;
    bus.EnableOut  = 1'b0;
    bus.halt       = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    checkEq("reset_segs", 64'(bus.Segs), 64'(segs4(c_DASH, c_DASH, c_DASH, c_DASH)));
    checkEq("reset_led", 64'(bus.Led), 64'd0);
    checkEq("reset_busy", 64'(bus.Busy), 64'd0);
    checkEq("reset_ovf", 64'(bus.Overflow), 64'd0);

    // 1234: Busy from edge k through k+32, display at k+33
    doWrite(32'd1234);
    checkEq("w1234_busy_k", 64'(bus.Busy), 64'd1);
    checkEq("w1234_led", 64'(bus.Led), 64'd1234);
    repeat (32) @(negedge Clock);
    checkEq("w1234_busy_k32", 64'(bus.Busy), 64'd1);
    checkEq("w1234_segs_k32", 64'(bus.Segs), 64'(segs4(c_DASH, c_DASH, c_DASH, c_DASH)));
    @(negedge Clock);
    checkEq("w1234_busy_k33", 64'(bus.Busy), 64'd0);
    checkEq("w1234_segs", 64'(bus.Segs), 64'(segs4(c_S1, c_S2, c_S3, c_S4)));
    checkEq("w1234_ovf", 64'(bus.Overflow), 64'd0);

    doWrite(32'd7);
    repeat (33) @(negedge Clock);
    checkEq("w7_segs", 64'(bus.Segs), 64'(segs4(c_BLANK, c_BLANK, c_BLANK, c_S7)));

    doWrite(32'd0);
    repeat (33) @(negedge Clock);
    checkEq("w0_segs", 64'(bus.Segs), 64'(segs4(c_BLANK, c_BLANK, c_BLANK, c_S0)));

    doWrite(32'd10000);
    repeat (33) @(negedge Clock);
    checkEq("w10000_ovf", 64'(bus.Overflow), 64'd1);
    checkEq("w10000_segs", 64'(bus.Segs), 64'(segs4(c_DASH, c_DASH, c_DASH, c_DASH)));

    doWrite(32'd9999);
    repeat (33) @(negedge Clock);
    checkEq("w9999_ovf", 64'(bus.Overflow), 64'd0);
    checkEq("w9999_segs", 64'(bus.Segs), 64'(segs4(c_S9, c_S9, c_S9, c_S9)));

    // Back-to-back: 11 at k, 22 at k+3, 33 at k+5
    doWrite(32'd11);
    repeat (2) @(negedge Clock);
    doWrite(32'd22);
    @(negedge Clock);
    doWrite(32'd33);
    checkEq("b2b_led33", 64'(bus.Led), 64'd33);
    for (int c = 6; c <= 67; c++) begin
      @(negedge Clock);
      if (c <= 66 && !bus.Busy) busyLow++;
      if (bus.Segs == seg22) saw22 = 1'b1;
      if (c == 33) checkEq("b2b_segs11_k33", 64'(bus.Segs), 64'(seg11));
      if (c == 66) checkEq("b2b_segs11_k66", 64'(bus.Segs), 64'(seg11));
    end
    checkEq("b2b_segs33_k67", 64'(bus.Segs), 64'(seg33));
    checkEq("b2b_busy_k67", 64'(bus.Busy), 64'd0);
    checkEq("b2b_busy_gaps", 64'(busyLow), 64'd0);
    checkEq("b2b_saw22", 64'(saw22), 64'd0);

    // Halt mid-conversion of 42; writes of 99 during halt are ignored
    doWrite(32'd42);
    repeat (5) @(negedge Clock);
    bus.halt = 1'b1;
    #1;
    checkEq("halt_led_before", 64'(bus.Led[LED_W-1]), 64'd0);
    @(negedge Clock);
    checkEq("halt_led_after", 64'(bus.Led[LED_W-1]), 64'd1);
    doWrite(32'd99);
    checkEq("halt_mirror", 64'(bus.Led[LED_W-2:0]), 64'd42);
    repeat (26) @(negedge Clock);
    checkEq("halt_segs42", 64'(bus.Segs), 64'(segs4(c_BLANK, c_BLANK, c_S4, c_S2)));
    checkEq("halt_busy_k33", 64'(bus.Busy), 64'd0);
    doWrite(32'd99);
    checkEq("halt_idle_busy", 64'(bus.Busy), 64'd0);
    bus.halt = 1'b0;
    @(negedge Clock);
    checkEq("unhalt_led", 64'(bus.Led[LED_W-1]), 64'd0);

    // Reset in the middle of a conversion aborts it
    doWrite(32'd5678);
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checkEq("rstmid_busy", 64'(bus.Busy), 64'd0);
    checkEq("rstmid_segs", 64'(bus.Segs), 64'(segs4(c_DASH, c_DASH, c_DASH, c_DASH)));
    checkEq("rstmid_led", 64'(bus.Led), 64'd0);
    Reset = 1'b0;
    repeat (40) @(negedge Clock);
    checkEq("rstmid_no_update", 64'(bus.Segs), 64'(segs4(c_DASH, c_DASH, c_DASH, c_DASH)));
    checkEq("rstmid_idle_busy", 64'(bus.Busy), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
